// File: rtl/genius_seq_player.sv
// genius_seq_player: stores a sequence of 2-bit colours and replays it one
// step at a time, driving the LED multiplexer select and the lamp enable.
// Optional build macro GENIUS_SEQ_EXT_COLOR_EN: adds EXT_COLOR and stores it
// on ADD_STEP instead of the LFSR colour (the LFSR keeps running regardless).
module genius_seq_player #(
   parameter int MAX_LEN   = 16,
   parameter int ON_TICKS  = 8,
   parameter int OFF_TICKS = 4
) (
   input  logic                               CLK,
   input  logic                               RST_N,
   input  logic                               CLEAR,
   input  logic                               ADD_STEP,
   input  logic                               START,
`ifdef GENIUS_SEQ_EXT_COLOR_EN
   input  logic [1:0]                         EXT_COLOR,
`endif
   output logic [1:0]                         SEL,
   output logic                               LED_EN,
   output logic                               BUSY,
   output logic                               DONE,
   output logic [$clog2(MAX_LEN+1)-1:0]       LEN,
   output logic                               FULL
);

   localparam int LW   = $clog2(MAX_LEN + 1);
   localparam int IW   = $clog2(MAX_LEN);
   localparam int TMAX = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
   localparam int CW   = $clog2(TMAX + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ON   = 2'd1,
      S_OFF  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t          state, state_n;
   logic [CW-1:0]   cnt, cnt_n;
   logic [IW-1:0]   idx, idx_n;
   logic [1:0]      sel, sel_n;
   logic [LW-1:0]   len, len_n;
   logic            full, led_en, busy, done;
   logic            wr_en;
   logic            last_step;
   logic [1:0]      colour;
   logic [7:0]      lfsr;
   logic [1:0]      mem [MAX_LEN];

`ifdef GENIUS_SEQ_EXT_COLOR_EN
   assign colour = EXT_COLOR;
`else
   assign colour = lfsr[1:0];
`endif

   assign last_step = (LW'(idx) == (len - LW'(1)));

   // Free-running colour source; keeps stepping even when not appending
   always_ff @(posedge CLK) begin
      if (!RST_N) lfsr <= 8'hA5;
      else        lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
   end

   // Sequence storage; contents are don't-care beyond LEN so no reset
   always_ff @(posedge CLK) begin
      if (RST_N && wr_en) mem[len[IW-1:0]] <= colour;
   end

   // State, counters and registered outputs
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state  <= S_IDLE;
         cnt    <= '0;
         idx    <= '0;
         sel    <= 2'b00;
         len    <= '0;
         full   <= 1'b0;
         led_en <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         idx    <= idx_n;
         sel    <= sel_n;
         len    <= len_n;
         full   <= (len_n == LW'(MAX_LEN));
         led_en <= (state_n == S_ON);
         busy   <= (state_n == S_ON) || (state_n == S_OFF);
         done   <= (state_n == S_DONE);
      end
   end

   // Next-state logic: CLEAR overrides everything, START beats ADD_STEP in IDLE
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      idx_n   = idx;
      sel_n   = sel;
      len_n   = len;
      wr_en   = 1'b0;
      if (CLEAR) begin
         state_n = S_IDLE;
         cnt_n   = '0;
         idx_n   = '0;
         sel_n   = 2'b00;
         len_n   = '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (START) begin
                  if (len != '0) begin
                     state_n = S_ON;
                     cnt_n   = '0;
                     idx_n   = '0;
                     sel_n   = mem[0];
                  end else begin
                     state_n = S_DONE;
                  end
               end else if (ADD_STEP && !full) begin
                  wr_en = 1'b1;
                  len_n = len + LW'(1);
               end
            end
            S_ON: begin
               if (cnt == CW'(ON_TICKS - 1)) begin
                  state_n = S_OFF;
                  cnt_n   = '0;
               end else begin
                  cnt_n = cnt + CW'(1);
               end
            end
            S_OFF: begin
               if (cnt == CW'(OFF_TICKS - 1)) begin
                  cnt_n = '0;
                  if (last_step) begin
                     state_n = S_DONE;
                  end else begin
                     state_n = S_ON;
                     idx_n   = idx + IW'(1);
                     sel_n   = mem[idx + IW'(1)];
                  end
               end else begin
                  cnt_n = cnt + CW'(1);
               end
            end
            S_DONE: begin
               state_n = S_IDLE;
            end
            default: begin
               state_n = S_IDLE;
            end
         endcase
      end
   end

   assign SEL    = sel;
   assign LED_EN = led_en;
   assign BUSY   = busy;
   assign DONE   = done;
   assign LEN    = len;
   assign FULL   = full;

endmodule

// File: doc/genius_seq_player.md
# genius_seq_player

Sequence store and playback engine for the Genius game datapath, sitting directly upstream of the 4-to-1, 4-bit LED/colour multiplexer. It appends pseudo-random colours to a stored sequence and replays that sequence one step at a time. During replay it drives the multiplexer's 2-bit `SEL` with the current colour and gates the lamp through `LED_EN`, using programmable on/off times.

## Interface
- `MAX_LEN`, 16: sequence capacity in steps; power of two, 4 to 64.
- `ON_TICKS`, 8: cycles `LED_EN` stays high per step; must be ≥1.
- `OFF_TICKS`, 4: cycles of dark gap after each step; must be ≥1.
- `CLK` in 1: single clock; all logic is rising-edge.
- `RST_N` in 1: reset, synchronous and active-low.
- `CLEAR` in 1: one-cycle pulse; empties the sequence and aborts any replay.
- `ADD_STEP` in 1: one-cycle pulse; appends one colour.
- `START` in 1: one-cycle pulse; replays the sequence.
- `SEL` out 2: colour index of the current step; feeds the multiplexer's `SEL`.
- `LED_EN` out 1: high during the ON phase of each step.
- `BUSY` out 1: high while replaying (ON or OFF state).
- `DONE` out 1: one-cycle pulse at the end of a replay.
- `LEN` out `$clog2(MAX_LEN+1)`: number of stored steps.
- `FULL` out 1: high when `LEN == MAX_LEN`.

## Operation
- **Storage.** `MAX_LEN` x 2-bit register array plus write pointer `LEN`.
- **Colour source.** 8-bit Fibonacci LFSR.
  - Reset value 8'hA5.
  - Every cycle while `RST_N` is high: shift left, new bit0 = b7^b5^b4^b3.
  - Appended colour = `lfsr[1:0]` as sampled at the `ADD_STEP` edge.
- **States.**
  - IDLE → ON when `START` is seen and `LEN > 0`. Loads step index 0 and `SEL = mem[0]`.
  - IDLE → DONE when `START` is seen and `LEN == 0`.
  - ON → OFF after `ON_TICKS` cycles in ON.
  - OFF → ON after `OFF_TICKS` cycles if another step remains. Increments the index and loads `SEL = mem[idx+1]`.
  - OFF → DONE after `OFF_TICKS` cycles on the last step.
  - DONE → IDLE unconditionally after one cycle.
- **Priority**, evaluated each cycle: `RST_N` low > `CLEAR` > `START` > `ADD_STEP`.
- **`CLEAR`.** Sets `LEN` to 0, returns the FSM to IDLE, drops `LED_EN` and `BUSY` at the next edge, and suppresses `DONE`. Stored data need not be zeroed.
- **`ADD_STEP`** is accepted only in IDLE with `FULL` low. When `FULL` is high, or when the block is busy or in DONE, it is silently ignored.
- **`START`** while BUSY or in DONE is ignored; a replay is never restarted mid-sequence.
- **Simultaneous `START` and `ADD_STEP` in IDLE.** `START` wins, `ADD_STEP` is dropped, and the replay uses the old `LEN`.
- **`SEL` in IDLE** holds the last replayed colour; it is 2'b00 after reset or `CLEAR`.

## Timing
- **Reset values.** `SEL` 2'b00, `LED_EN` 0, `BUSY` 0, `DONE` 0, `LEN` 0, `FULL` 0, FSM IDLE, LFSR 8'hA5.
- **All outputs are registered.** A `START` sampled at edge k gives `BUSY`, `LED_EN` and a valid `SEL` from edge k onward, i.e. visible in cycle k+1.
- **Per step:** exactly `ON_TICKS` cycles with `LED_EN` = 1, then `OFF_TICKS` cycles with `LED_EN` = 0. `SEL` is stable for the whole step and changes only on the OFF→ON edge.
- **Replay length.** `LEN`·(`ON_TICKS`+`OFF_TICKS`) cycles with `BUSY` high. `DONE` rises on the edge `BUSY` falls, for exactly one cycle.
- **Empty replay.** A `START` at edge k with `LEN == 0` gives `DONE` high in cycle k+1, with `BUSY` never asserted.
- **Append.** `ADD_STEP` at edge k updates `LEN` (and `FULL`, when it reaches `MAX_LEN`) at edge k.
- **Wrap-around.** `LEN` never exceeds `MAX_LEN`; there is no wrap.

## Configuration
- **`GENIUS_SEQ_EXT_COLOR_EN`**
  - Defined: adds input port `EXT_COLOR` in 2, and `ADD_STEP` stores `EXT_COLOR` instead of `lfsr[1:0]`. The LFSR is still present and clocked but unused for storage. Intended for deterministic test and for a demo mode.
  - Undefined: no `EXT_COLOR` port; colours come from the LFSR.

## Test plan
1. **Reset and LFSR source** (macro undefined): release reset, pulse `ADD_STEP` on the first cycle → `LEN` = 1, `mem[0]` = 2'b01 (from 8'hA5). All other outputs hold their reset values.
2. **Replay** (macro defined, `ON_TICKS`=8, `OFF_TICKS`=4): append 3, 0, 2, then `START` → `SEL` sequence 3, 0, 2. Each step has 8 cycles with `LED_EN` high and 4 low. `BUSY` is high for 36 cycles, then `DONE` is high for 1 cycle.
3. **Full sequence** (`MAX_LEN`=16): pulse `ADD_STEP` 17 times → `LEN` = 16 and `FULL` = 1. The 17th pulse changes nothing.
4. **Abort:** during the 2nd step of a replay, pulse `CLEAR` → next cycle `LED_EN` = 0, `BUSY` = 0, `LEN` = 0, no `DONE`. A following `START` gives a `DONE` pulse one cycle later.
5. **Collisions:** `START` and `ADD_STEP` in the same IDLE cycle with `LEN` = 2 → replay of 2 steps and `LEN` stays 2. `START` and `ADD_STEP` pulsed while BUSY are both ignored.
6. **Reset mid-replay:** drop `RST_N` in the ON phase → at the next edge all outputs return to reset values and `LEN` = 0.
